inst_fetcher: RTL
=================

// Module: inst_fetcher
// PURPOSE
//  Producer side of the instruction decoder: keeps a PC, issues word fetches to the memory controller,
//  and buffers {pc, inst} pairs in an in-order queue. The queue head goes to decode/dispatch over a valid/ready handshake.
//  Redirects (branch mispredict, jalr resolution) arrive as a flush from the commit/ROB side.
// PARAMETERS
//  QUEUE_DEPTH_LOG  3      log2 of queue entries (depth 8)
//  RESET_PC         32'h0  PC loaded on reset
// PORTS
//  clk_in          in   1   clock; all state updates on posedge
//  rst_in          in   1   reset, synchronous, active-high
//  rdy_in          in   1   global enable; low -> every register holds its value
//  mem_req_valid   out  1   fetch request pending to memory controller
//  mem_req_addr    out  32  word address of pending fetch
//  mem_resp_valid  in   1   one-cycle pulse: mem_resp_data is valid
//  mem_resp_data   in   32  fetched instruction word
//  inst_valid      out  1   queue head valid
//  inst            out  32  queue head instruction (INST_TYPE)
//  inst_pc         out  32  queue head PC
//  inst_ready      in   1   consumer accepts head this cycle
//  flush_in        in   1   discard all fetched/in-flight work, restart at flush_pc
//  flush_pc        in   32  restart PC
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, state=IDLE, mem_req_valid=0, mem_req_addr=0, inst_valid=0, inst=0, inst_pc=0.
//  At most one fetch outstanding. The memory controller shares rdy_in and never pulses mem_resp_valid while rdy_in=0.
//  FSM (registered outputs):
//   IDLE: if count<2**QUEUE_DEPTH_LOG: next cycle mem_req_valid=1, mem_req_addr=pc, go WAIT; else stay.
//   WAIT: mem_req_valid held 1, addr stable. On mem_resp_valid: push {pc,data}, update pc, mem_req_valid=0, go IDLE.
//   DROP: in-flight fetch is stale. mem_req_valid held 1 with the old addr. On mem_resp_valid: discard data, mem_req_valid=0, go IDLE.
//  Steady-state throughput: one fetch per (memory latency + 1) cycles; IDLE is a one-cycle bubble.
//  Next pc after push: pc+4, wrapping modulo 2**32.
//  Queue: inst_valid = !empty. Pop on inst_valid&&inst_ready. Push and pop in the same cycle are both honoured (count unchanged).
//   Full+push cannot occur: issue requires free space, and count only falls while WAIT.
//  Flush (priority over push, pop and issue, same edge):
//   - Queue emptied; inst_valid=0 next cycle; pc=flush_pc.
//   - IDLE -> IDLE: the request for flush_pc is issued on the following cycle.
//   - WAIT without resp -> DROP.
//   - WAIT with resp in the same cycle -> response discarded, go IDLE.
//   - DROP -> DROP with pc updated; a resp in the same cycle is discarded, go IDLE.
//   - Flush while rdy_in=0 is ignored (upstream holds flush until rdy_in=1).
//  rst_in mid-WAIT/DROP: return to reset state. The memory controller is reset by the same rst_in, so no stale resp arrives.
// CONFIGURATION
//  IFETCH_JAL_PREDICT_EN defined:
//   - On push, if data[6:0]==7'b1101111 (JAL), next pc = pc + sext({data[31],data[19:12],data[20],data[30:21],1'b0}).
//   - The JAL is still pushed to the queue unchanged.
//  Undefined: next pc always pc+4. Downstream resolves JAL via flush.
// STRUCTURE
//  config.v supplies:
//   - widths INST_TYPE, ADDR_TYPE, OPCODE_RANGE
//   - JAL opcode constant
//   - fetch state encodings IF_IDLE/IF_WAIT/IF_DROP
//  Sub-module inst_queue: circular FIFO of {pc,inst} with head/tail pointers of QUEUE_DEPTH_LOG bits plus a count.
//   Ports: push, pop, clear, full, empty, head data.
//  inst_fetcher holds the FSM, pc, request registers and JAL target adder.
// TESTING
//  1. Reset, rdy_in=1, memory latency 2, inst_ready=1, words 0x00000013 -> req addrs 0,4,8; inst_pc 0,4,8 with inst 0x00000013 in order.
//  2. inst_ready=0, fill queue -> after 8 pushes mem_req_valid stays 0. One pop -> next req addr 0x20.
//  3. flush_in, flush_pc=0x100 in WAIT at addr 0x8; late resp 0xdeadbeef -> never on inst, inst_valid=0, next req addr 0x100.
//  4. flush coinciding with mem_resp_valid and a pop -> queue empty, resp dropped, FSM IDLE, next req addr = flush_pc.
//  5. JAL 0x0080006f fetched at pc 0x10 -> next req 0x18 with IFETCH_JAL_PREDICT_EN, 0x14 without.
//  6. rdy_in=0 for 5 cycles mid-WAIT -> all outputs frozen. Resume: same addr, no duplicate or lost entry.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher.
//   inst_t / addr_t   : instruction word and byte address widths
//   fetch_entry_t     : one queue entry, {pc, inst}
//   IF_IDLE/IF_WAIT/IF_DROP : fetch FSM encodings
//   OPCODE_JAL        : opcode of the JAL instruction
//   jal_target()      : pc-relative JAL destination
package inst_fetcher_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  localparam logic [1:0] IF_IDLE = 2'd0;
  localparam logic [1:0] IF_WAIT = 2'd1;
  localparam logic [1:0] IF_DROP = 2'd2;

  function automatic logic is_jal(input inst_t data);
    return data[6:0] == OPCODE_JAL;
  endfunction

  // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} scattered in
  // the word; bit 0 of the offset is always zero.
  function automatic addr_t jal_target(input addr_t pc, input inst_t data);
    addr_t imm;
    imm = {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0};
    return pc + imm;
  endfunction
endpackage

// File: rtl/inst_fetcher_queue.sv
// In-order circular FIFO of {pc, inst} entries.
//   clk_in, rst_in : clock, synchronous active-high reset
//   push_in        : write push_entry at the tail (ignored when full)
//   pop_in         : drop the head entry (ignored when empty)
//   clear_in       : empty the queue; wins over push and pop
//   full_out       : all 2**DEPTH_LOG entries occupied
//   empty_out      : no entries
//   head_entry     : head entry, zero while empty
// The caller gates push/pop/clear with its global enable, so with all three
// low every register here holds.
module inst_fetcher_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH_LOG = 3
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push_in,
  input  logic         pop_in,
  input  logic         clear_in,
  input  fetch_entry_t push_entry,
  output logic         full_out,
  output logic         empty_out,
  output fetch_entry_t head_entry
);
  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [DEPTH_LOG-1:0] head_q, head_d;
  logic [DEPTH_LOG-1:0] tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  fetch_entry_t         mem_q [DEPTH];
  fetch_entry_t         mem_d [DEPTH];
  logic                 do_push;
  logic                 do_pop;

  assign full_out   = (count_q == (DEPTH_LOG+1)'(DEPTH));
  assign empty_out  = (count_q == '0);
  assign head_entry = empty_out ? '0 : mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push_in && !full_out;
    do_pop  = pop_in && !empty_out;
    if (clear_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + 1'b1;
      end
      if (do_pop) begin
        head_d = head_q + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end
endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: keeps the PC, issues one word fetch at a time to the
// memory controller and buffers {pc, inst} pairs for decode.
//   clk_in, rst_in   : clock, synchronous active-high reset
//   rdy_in           : global enable; low freezes every register
//   mem_req_valid/addr : registered fetch request (held until the response)
//   mem_resp_valid/data: one-cycle response pulse and instruction word
//   inst_valid/inst/inst_pc/inst_ready : queue head to decode
//   flush_in/flush_pc : redirect; discards queued and in-flight work
//   dbg_state        : current fetch FSM state (IF_IDLE/IF_WAIT/IF_DROP)
// Optional build macro IFETCH_JAL_PREDICT_EN: when defined, a fetched JAL
// redirects the next fetch to its target; otherwise fetch is always pc+4.
//
// Handshake: a head entry transfers on a rising edge where rdy_in,
// inst_valid and inst_ready are all high; inst_valid never depends on
// inst_ready. A transfer coinciding with flush_in is discarded by the flush.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH_LOG = 3,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic [1:0]  dbg_state
);
  logic [1:0]   state_q, state_d;
  addr_t        pc_q, pc_d;
  logic         req_valid_q, req_valid_d;
  addr_t        req_addr_q, req_addr_d;
  addr_t        next_pc;

  logic         q_push;
  logic         q_pop;
  logic         q_clear;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;

  inst_fetcher_queue #(
    .DEPTH_LOG (QUEUE_DEPTH_LOG)
  ) u_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push_in    (q_push),
    .pop_in     (q_pop),
    .clear_in   (q_clear),
    .push_entry ({pc_q, mem_resp_data}),
    .full_out   (q_full),
    .empty_out  (q_empty),
    .head_entry (q_head)
  );

  assign inst_valid    = !q_empty;
  assign inst          = q_head.inst;
  assign inst_pc       = q_head.pc;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign dbg_state     = state_q;

  assign q_pop = rdy_in && !flush_in && inst_valid && inst_ready;

`ifdef IFETCH_JAL_PREDICT_EN
  assign next_pc = is_jal(mem_resp_data) ? jal_target(pc_q, mem_resp_data)
                                         : pc_q + 32'd4;
`else
  assign next_pc = pc_q + 32'd4;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    q_push      = 1'b0;
    q_clear     = 1'b0;
    if (rdy_in) begin
      if (flush_in) begin
        // Redirect: in-flight fetch becomes stale, its response is dropped.
        pc_d    = flush_pc;
        q_clear = 1'b1;
        case (state_q)
          IF_IDLE: state_d = IF_IDLE;
          IF_WAIT, IF_DROP: begin
            if (mem_resp_valid) begin
              req_valid_d = 1'b0;
              state_d     = IF_IDLE;
            end else begin
              state_d     = IF_DROP;
            end
          end
          default: begin
            req_valid_d = 1'b0;
            state_d     = IF_IDLE;
          end
        endcase
      end else begin
        case (state_q)
          IF_IDLE: begin
            // Only issue with a free slot so the response always fits.
            if (!q_full) begin
              req_valid_d = 1'b1;
              req_addr_d  = pc_q;
              state_d     = IF_WAIT;
            end
          end
          IF_WAIT: begin
            if (mem_resp_valid) begin
              q_push      = 1'b1;
              pc_d        = next_pc;
              req_valid_d = 1'b0;
              state_d     = IF_IDLE;
            end
          end
          IF_DROP: begin
            if (mem_resp_valid) begin
              req_valid_d = 1'b0;
              state_d     = IF_IDLE;
            end
          end
          default: begin
            req_valid_d = 1'b0;
            state_d     = IF_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IF_IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
    end
  end
endmodule
